// File: rtl/subleq_sequencer.sv
// SUBLEQ control sequencer: drives register STORE/SHOW strobes and the memory handshake for one instruction at a time.
// Optional memory-access timeout to a sticky FAULT state is enabled by defining SUBLEQ_MEM_TIMEOUT_EN.
module subleq_sequencer #(
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  CLOCK,
  input  logic                  RESET_bar,
  input  logic                  RUN,
  input  logic                  MEM_READY,
  input  logic                  ALU_LEQZ,
  input  logic [DATA_WIDTH-1:0] C_VAL,
  output logic [7:0]            STORE_EN,
  output logic [7:0]            SHOW_EN,
  output logic                  PC_INC,
  output logic                  MEM_RD,
  output logic                  MEM_WR,
  output logic                  BUSY,
  output logic                  HALTED,
  output logic                  FAULT,
  output logic [3:0]            STATE
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FA    = 4'd1,
    S_RA    = 4'd2,
    S_FB    = 4'd3,
    S_RB    = 4'd4,
    S_FC    = 4'd5,
    S_RC    = 4'd6,
    S_LA    = 4'd7,
    S_RDA   = 4'd8,
    S_LB    = 4'd9,
    S_RDB   = 4'd10,
    S_EXEC  = 4'd11,
    S_WR    = 4'd12,
    S_BR    = 4'd13,
    S_HALT  = 4'd14,
    S_FAULT = 4'd15
  } state_e;

  state_e      state_r;
  state_e      state_next_s;
  logic        leqz_r;
  logic        halt_hit_s;
  logic        timeout_s;
  logic [7:0]  store_en_s;
  logic [7:0]  show_en_s;
  logic        pc_inc_s;
  logic        mem_rd_s;
  logic        mem_wr_s;

  // An all-ones C with a taken branch is the halt encoding.
  assign halt_hit_s = leqz_r && (&C_VAL);

`ifdef SUBLEQ_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 2);

  logic             mem_state_s;
  logic [CNT_W-1:0] wait_cnt_r;

  assign mem_state_s = (state_r == S_RA)  || (state_r == S_RB)  || (state_r == S_RC) ||
                       (state_r == S_RDA) || (state_r == S_RDB) || (state_r == S_WR);

  // Wait-cycle counter for the current memory state; restarts on every state change.
  always_ff @(posedge CLOCK or negedge RESET_bar) begin
    if (!RESET_bar) begin
      wait_cnt_r <= '0;
    end else if (state_next_s != state_r) begin
      wait_cnt_r <= '0;
    end else if (mem_state_s) begin
      wait_cnt_r <= wait_cnt_r + CNT_W'(1'b1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = mem_state_s && !MEM_READY && (wait_cnt_r == CNT_W'(MEM_TIMEOUT));
  assign FAULT     = (state_r == S_FAULT);
`else
  logic [7:0] unused_timeout_s;

  assign unused_timeout_s = 8'(MEM_TIMEOUT);
  assign timeout_s        = 1'b0;
  assign FAULT            = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLOCK or negedge RESET_bar) begin
    if (!RESET_bar) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Branch flag captured in EXEC so BR does not depend on the ALU inputs still being valid.
  always_ff @(posedge CLOCK or negedge RESET_bar) begin
    if (!RESET_bar) begin
      leqz_r <= 1'b0;
    end else if (state_r == S_EXEC) begin
      leqz_r <= ALU_LEQZ;
    end else begin
      leqz_r <= leqz_r;
    end
  end

  // Next-state logic; memory states hold until MEM_READY (or time out when enabled).
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (RUN) state_next_s = S_FA;
        else     state_next_s = S_IDLE;
      end
      S_FA:   state_next_s = S_RA;
      S_FB:   state_next_s = S_RB;
      S_FC:   state_next_s = S_RC;
      S_LA:   state_next_s = S_RDA;
      S_LB:   state_next_s = S_RDB;
      S_EXEC: state_next_s = S_WR;
      S_RA, S_RB, S_RC, S_RDA, S_RDB, S_WR: begin
        if (MEM_READY) begin
          case (state_r)
            S_RA:    state_next_s = S_FB;
            S_RB:    state_next_s = S_FC;
            S_RC:    state_next_s = S_LA;
            S_RDA:   state_next_s = S_LB;
            S_RDB:   state_next_s = S_EXEC;
            S_WR:    state_next_s = S_BR;
            default: state_next_s = S_IDLE;
          endcase
        end else if (timeout_s) begin
          state_next_s = S_FAULT;
        end else begin
          state_next_s = state_r;
        end
      end
      S_BR: begin
        if (halt_hit_s) state_next_s = S_HALT;
        else if (RUN)   state_next_s = S_FA;
        else            state_next_s = S_IDLE;
      end
      S_HALT:  state_next_s = S_HALT;
      S_FAULT: state_next_s = S_FAULT;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Strobe decode: Moore from state, except STORE_EN in read states which waits for MEM_READY.
  always_comb begin
    store_en_s = 8'h00;
    show_en_s  = 8'h00;
    pc_inc_s   = 1'b0;
    mem_rd_s   = 1'b0;
    mem_wr_s   = 1'b0;
    case (state_r)
      S_FA, S_FB, S_FC: begin
        show_en_s[0]  = 1'b1;
        store_en_s[1] = 1'b1;
        pc_inc_s      = 1'b1;
      end
      S_RA, S_RB, S_RC, S_RDA, S_RDB: begin
        mem_rd_s = 1'b1;
        if (MEM_READY) begin
          case (state_r)
            S_RA:    store_en_s[2] = 1'b1;
            S_RB:    store_en_s[3] = 1'b1;
            S_RC:    store_en_s[4] = 1'b1;
            S_RDA:   store_en_s[5] = 1'b1;
            S_RDB:   store_en_s[6] = 1'b1;
            default: store_en_s    = 8'h00;
          endcase
        end else begin
          store_en_s = 8'h00;
        end
      end
      S_LA: begin
        show_en_s[2]  = 1'b1;
        store_en_s[1] = 1'b1;
      end
      S_LB: begin
        show_en_s[3]  = 1'b1;
        store_en_s[1] = 1'b1;
      end
      S_EXEC: store_en_s[7] = 1'b1;
      S_WR: begin
        show_en_s[7] = 1'b1;
        mem_wr_s     = 1'b1;
      end
      S_BR: begin
        if (leqz_r && !halt_hit_s) begin
          show_en_s[4]  = 1'b1;
          store_en_s[0] = 1'b1;
        end else begin
          show_en_s  = 8'h00;
          store_en_s = 8'h00;
        end
      end
      default: begin
        store_en_s = 8'h00;
        show_en_s  = 8'h00;
      end
    endcase
  end

  assign STORE_EN = store_en_s;
  assign SHOW_EN  = show_en_s;
  assign PC_INC   = pc_inc_s;
  assign MEM_RD   = mem_rd_s;
  assign MEM_WR   = mem_wr_s;
  assign STATE    = state_r;
  assign HALTED   = (state_r == S_HALT);
  assign BUSY     = (state_r != S_IDLE) && (state_r != S_HALT) && (state_r != S_FAULT);

  subleq_sequencer_checker u_checker (
    .CLOCK     (CLOCK),
    .RESET_bar (RESET_bar),
    .SHOW_EN   (SHOW_EN),
    .MEM_RD    (MEM_RD)
  );

endmodule

// Bus-ownership properties: at most one register drives the bus, never alongside memory.
module subleq_sequencer_checker (
  input logic       CLOCK,
  input logic       RESET_bar,
  input logic [7:0] SHOW_EN,
  input logic       MEM_RD
);

  a_show_onehot0: assert property (@(posedge CLOCK) disable iff (!RESET_bar) $onehot0(SHOW_EN));
  a_show_vs_rd:   assert property (@(posedge CLOCK) disable iff (!RESET_bar) !((|SHOW_EN) && MEM_RD));

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer: reset, zero-wait sequencing, branch, halt, wait states, timeout.
module tb_subleq_sequencer;

  logic       CLOCK;
  logic       RESET_bar;
  logic       RUN;
  logic       MEM_READY;
  logic       ALU_LEQZ;
  logic [7:0] C_VAL;
  logic [7:0] STORE_EN;
  logic [7:0] SHOW_EN;
  logic       PC_INC;
  logic       MEM_RD;
  logic       MEM_WR;
  logic       BUSY;
  logic       HALTED;
  logic       FAULT;
  logic [3:0] STATE;

  int errors = 0;
  int checks = 0;
  int pc_cnt;
  int st0_cnt;
  int rd_cnt;

  subleq_sequencer dut (
    .CLOCK     (CLOCK),
    .RESET_bar (RESET_bar),
    .RUN       (RUN),
    .MEM_READY (MEM_READY),
    .ALU_LEQZ  (ALU_LEQZ),
    .C_VAL     (C_VAL),
    .STORE_EN  (STORE_EN),
    .SHOW_EN   (SHOW_EN),
    .PC_INC    (PC_INC),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .BUSY      (BUSY),
    .HALTED    (HALTED),
    .FAULT     (FAULT),
    .STATE     (STATE)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected strobes for each state with MEM_READY held high and no branch.
  function automatic logic [7:0] exp_store(input int s);
    case (s)
      1, 3, 5, 7, 9: return 8'h02;
      2:  return 8'h04;
      4:  return 8'h08;
      6:  return 8'h10;
      8:  return 8'h20;
      10: return 8'h40;
      11: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_show(input int s);
    case (s)
      1, 3, 5: return 8'h01;
      7:  return 8'h04;
      9:  return 8'h08;
      12: return 8'h80;
      default: return 8'h00;
    endcase
  endfunction

  initial begin
    RESET_bar = 1'b0;
    RUN       = 1'b0;
    MEM_READY = 1'b0;
    ALU_LEQZ  = 1'b0;
    C_VAL     = 8'h00;
    #1;
    chk("rst_state", STATE, 4'd0);
    chk("rst_store", STORE_EN, 8'h00);
    chk("rst_show", SHOW_EN, 8'h00);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_halted", HALTED, 1'b0);
    chk("rst_fault", FAULT, 1'b0);
    tick();
    tick();
    RESET_bar = 1'b1;

    // Idle with RUN low
    repeat (3) begin
      tick();
      chk("idle_state", STATE, 4'd0);
      chk("idle_store", STORE_EN, 8'h00);
      chk("idle_show", SHOW_EN, 8'h00);
      chk("idle_pc", PC_INC, 1'b0);
    end

    // Zero-wait instruction
    RUN       = 1'b1;
    MEM_READY = 1'b1;
    pc_cnt    = 0;
    st0_cnt   = 0;
    for (int s = 1; s <= 13; s++) begin
      tick();
      chk("zw_state", STATE, s);
      chk("zw_store", STORE_EN, exp_store(s));
      chk("zw_show", SHOW_EN, exp_show(s));
      chk("zw_rd", MEM_RD, (s == 2 || s == 4 || s == 6 || s == 8 || s == 10) ? 1'b1 : 1'b0);
      chk("zw_wr", MEM_WR, (s == 12) ? 1'b1 : 1'b0);
      chk("zw_pc", PC_INC, (s == 1 || s == 3 || s == 5) ? 1'b1 : 1'b0);
      chk("zw_busy", BUSY, 1'b1);
      if (PC_INC) pc_cnt++;
      if (STORE_EN[0]) st0_cnt++;
    end
    tick();
    chk("zw_wrap", STATE, 4'd1);
    chk("zw_pc_count", pc_cnt, 3);
    chk("zw_store0_count", st0_cnt, 0);

    // Branch taken
    ALU_LEQZ = 1'b1;
    C_VAL    = 8'h20;
    repeat (12) tick();
    chk("br_state", STATE, 4'd13);
    chk("br_store", STORE_EN, 8'h01);
    chk("br_show", SHOW_EN, 8'h10);
    ALU_LEQZ = 1'b0;
    tick();
    chk("br_next", STATE, 4'd1);
    chk("br_next_store", STORE_EN, 8'h02);

    // Halt
    ALU_LEQZ = 1'b1;
    C_VAL    = 8'hFF;
    repeat (12) tick();
    chk("hlt_br_state", STATE, 4'd13);
    chk("hlt_br_store", STORE_EN, 8'h00);
    chk("hlt_br_show", SHOW_EN, 8'h00);
    tick();
    chk("hlt_state", STATE, 4'd14);
    chk("hlt_halted", HALTED, 1'b1);
    chk("hlt_busy", BUSY, 1'b0);
    chk("hlt_store", STORE_EN, 8'h00);
    repeat (4) begin
      RUN = ~RUN;
      tick();
      chk("hlt_stick_state", STATE, 4'd14);
      chk("hlt_stick_halted", HALTED, 1'b1);
    end
    #2;
    RESET_bar = 1'b0;
    #1;
    chk("hlt_rst_state", STATE, 4'd0);
    chk("hlt_rst_halted", HALTED, 1'b0);
    tick();
    RESET_bar = 1'b1;

    // Wait states in RDB, RUN dropped mid-instruction
    RUN       = 1'b1;
    MEM_READY = 1'b1;
    ALU_LEQZ  = 1'b0;
    C_VAL     = 8'h00;
    tick();
    chk("ws_fa", STATE, 4'd1);
    repeat (8) tick();
    chk("ws_lb", STATE, 4'd9);
    MEM_READY = 1'b0;
    rd_cnt    = 0;
    repeat (3) begin
      tick();
      RUN = 1'b0;
      #1;
      chk("ws_rdb_state", STATE, 4'd10);
      chk("ws_rdb_rd", MEM_RD, 1'b1);
      chk("ws_rdb_store", STORE_EN, 8'h00);
      if (MEM_RD) rd_cnt++;
    end
    tick();
    MEM_READY = 1'b1;
    #1;
    chk("ws_rdb_last_state", STATE, 4'd10);
    chk("ws_rdb_last_store", STORE_EN, 8'h40);
    if (MEM_RD) rd_cnt++;
    chk("ws_rd_count", rd_cnt, 4);
    tick();
    chk("ws_exec", STATE, 4'd11);
    chk("ws_exec_store", STORE_EN, 8'h80);
    tick();
    chk("ws_wr", MEM_WR, 1'b1);
    tick();
    chk("ws_br", STATE, 4'd13);
    tick();
    chk("ws_idle", STATE, 4'd0);
    chk("ws_idle_busy", BUSY, 1'b0);

    // Asynchronous reset while MEM_WR is high
    RUN = 1'b1;
    tick();
    repeat (10) tick();
    chk("rw_exec", STATE, 4'd11);
    MEM_READY = 1'b0;
    tick();
    chk("rw_wr_state", STATE, 4'd12);
    chk("rw_wr", MEM_WR, 1'b1);
    tick();
    chk("rw_wr_hold", MEM_WR, 1'b1);
    #2;
    RESET_bar = 1'b0;
    #1;
    chk("rw_rst_wr", MEM_WR, 1'b0);
    chk("rw_rst_show", SHOW_EN, 8'h00);
    chk("rw_rst_state", STATE, 4'd0);
    chk("rw_rst_busy", BUSY, 1'b0);
    tick();
    RESET_bar = 1'b1;

    // Memory never ready in RA
    tick();
    chk("to_fa", STATE, 4'd1);
    tick();
    chk("to_ra_first", STATE, 4'd2);
    repeat (15) tick();
    chk("to_ra_16th", STATE, 4'd2);
    chk("to_ra_rd", MEM_RD, 1'b1);
    tick();
`ifdef SUBLEQ_MEM_TIMEOUT_EN
    chk("to_fault_state", STATE, 4'd15);
    chk("to_fault", FAULT, 1'b1);
    chk("to_fault_rd", MEM_RD, 1'b0);
    chk("to_fault_store", STORE_EN, 8'h00);
    chk("to_fault_busy", BUSY, 1'b0);
    MEM_READY = 1'b1;
    tick();
    chk("to_fault_sticky", STATE, 4'd15);
`else
    chk("to_wait_state", STATE, 4'd2);
    chk("to_no_fault", FAULT, 1'b0);
    repeat (20) tick();
    chk("to_wait_long", STATE, 4'd2);
    chk("to_wait_rd", MEM_RD, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
